led_matrix_pwm_scan: RTL

//  Parametrised multiplexed LED-matrix driver with per-LED PWM brightness. Takes a full frame of

---
 rtl/led_matrix_pkg.sv | 24 ++
 rtl/led_pwm_cmp.sv | 34 +++
 rtl/led_matrix_pwm_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the multiplexed LED-matrix PWM driver.
// Default geometry, scan-period figures, idle pad levels and the frame index helper.
package led_matrix_pkg;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_SLOT_CLKS  = 32;
    localparam int DEF_BLANK_CLKS = 2;

    // One full column scan, and one full PWM frame (every phase value visited once)
    localparam int SCAN_CLKS      = DEF_SLOT_CLKS * DEF_COLS;
    localparam int PWM_FRAME_CLKS = SCAN_CLKS * (2 ** DEF_PWM_BITS);

    // Per-bit idle levels: anodes are active-low, cathode enables active-high
    localparam logic ALED_OFF = 1'b1;
    localparam logic KLED_OFF = 1'b0;

    // Flat frame index of the LED at (row, col)
    function automatic int led_idx(input int row, input int col, input int cols);
        return (row * cols) + col;
    endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// Per-row PWM comparator: turns a brightness value and the running phase into an on bit.
// Optional global dimming is compiled in with the LED_GLOBAL_DIM_EN macro; without it the
// dim input is ignored and no multiplier exists.
module led_pwm_cmp #(
    parameter int PWM_BITS = 8
) (
    input  logic [PWM_BITS-1:0] value,
    input  logic [7:0]          dim,
    input  logic [PWM_BITS-1:0] phase,
    output logic                on
);

`ifdef LED_GLOBAL_DIM_EN
    logic [PWM_BITS+8:0] prod_s;
    logic [PWM_BITS-1:0] eff_s;

    // Scale by (dim+1)/256 so dim=255 is identity, then compare against the phase
    always_comb begin
        prod_s = (PWM_BITS+9)'(value) * (PWM_BITS+9)'({1'b0, dim} + 9'd1);
        eff_s  = prod_s[PWM_BITS+7:8];
        on     = (eff_s > phase);
    end
`else
    logic unused_dim_s;

    assign unused_dim_s = ^dim;

    // Undimmed: LED is on while its value exceeds the phase, so value 0 never lights
    always_comb begin
        on = (value > phase);
    end
`endif

endmodule

// File: rtl/led_matrix_pwm_scan.sv
// Multiplexed LED-matrix driver with per-LED PWM brightness and a double-buffered frame.
// A new frame waits in the pending buffer and is swapped into the active buffer only at the
// end of a full column scan, so a scan never mixes two frames. Each column slot begins with a
// short all-off window to suppress ghosting. Optional macro: LED_GLOBAL_DIM_EN (global dim).
module led_matrix_pwm_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int SLOT_CLKS  = DEF_SLOT_CLKS,
    parameter int BLANK_CLKS = DEF_BLANK_CLKS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS*COLS*PWM_BITS-1:0] frame_data,
    input  logic                         frame_load,
    input  logic [7:0]                   dim,
    output logic [COLS-1:0]              aled,
    output logic [ROWS-1:0]              kled_tri,
    output logic                         swap_done,
    output logic                         scan_sync
);

    localparam int FRAME_W = ROWS * COLS * PWM_BITS;
    localparam int SLOT_W  = $clog2(SLOT_CLKS);
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CLKS - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CLKS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    logic [SLOT_W-1:0]   slot_cnt_r;
    logic [COL_W-1:0]    col_r;
    logic [PWM_BITS-1:0] phase_r;
    logic [FRAME_W-1:0]  pending_r;
    logic [FRAME_W-1:0]  active_r;
    logic                pending_flag_r;
    logic                swapped_r;
    logic [COLS-1:0]     aled_r;
    logic [ROWS-1:0]     kled_tri_r;
    logic                swap_done_r;
    logic                scan_sync_r;

    logic                slot_wrap_s;
    logic                swap_point_s;
    logic                lit_s;
    logic [PWM_BITS-1:0] row_val_s [ROWS];
    logic [ROWS-1:0]     on_s;
    logic [COLS-1:0]     aled_s;
    logic [ROWS-1:0]     kled_s;

    assign slot_wrap_s  = (slot_cnt_r == SLOT_LAST);
    assign swap_point_s = slot_wrap_s && (col_r == COL_LAST);

    // Slot, column and PWM phase counters; phase advances once per full scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_r <= '0;
            col_r      <= '0;
            phase_r    <= '0;
        end else if (slot_wrap_s) begin
            slot_cnt_r <= '0;
            if (col_r == COL_LAST) begin
                col_r   <= '0;
                phase_r <= phase_r + PWM_BITS'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
        end
    end

    // Double buffer: loads land in pending, and reach active only at the scan boundary.
    // A load on the boundary itself bypasses pending so it is neither lost nor shown twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r      <= '0;
            active_r       <= '0;
            pending_flag_r <= 1'b0;
            swapped_r      <= 1'b0;
        end else begin
            swapped_r <= 1'b0;
            if (swap_point_s && frame_load) begin
                active_r       <= frame_data;
                pending_flag_r <= 1'b0;
                swapped_r      <= 1'b1;
            end else if (swap_point_s && pending_flag_r) begin
                active_r       <= pending_r;
                pending_flag_r <= 1'b0;
                swapped_r      <= 1'b1;
            end else if (frame_load) begin
                pending_r      <= frame_data;
                pending_flag_r <= 1'b1;
            end
        end
    end

    // Pick each row's brightness for the column currently being scanned
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_val_s[r] = active_r[led_idx(r, int'(col_r), COLS)*PWM_BITS +: PWM_BITS];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        led_pwm_cmp #(.PWM_BITS(PWM_BITS)) u_cmp (
            .value (row_val_s[r]),
            .dim   (dim),
            .phase (phase_r),
            .on    (on_s[r])
        );
    end

    // Next pad state: everything off in the blank window, one anode low while lit
    always_comb begin
        lit_s  = (slot_cnt_r >= BLANK_END);
        aled_s = {COLS{ALED_OFF}};
        kled_s = {ROWS{KLED_OFF}};
        if (lit_s) begin
            aled_s[col_r] = ~ALED_OFF;
            kled_s        = on_s;
        end else begin
            aled_s = {COLS{ALED_OFF}};
            kled_s = {ROWS{KLED_OFF}};
        end
    end

    // Output registers: pads and pulses follow the previous cycle's counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aled_r      <= {COLS{ALED_OFF}};
            kled_tri_r  <= {ROWS{KLED_OFF}};
            swap_done_r <= 1'b0;
            scan_sync_r <= 1'b0;
        end else begin
            aled_r      <= aled_s;
            kled_tri_r  <= kled_s;
            swap_done_r <= swapped_r;
            scan_sync_r <= (slot_cnt_r == '0) && (col_r == '0);
        end
    end

    assign aled      = aled_r;
    assign kled_tri  = kled_tri_r;
    assign swap_done = swap_done_r;
    assign scan_sync = scan_sync_r;

endmodule
